// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit.
// Holds the opcodes, FSM states and the datapath select/operation codes.
package riscv_ctrl_pkg;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite,
        StExecR, StExecI, StAluWb, StBranch, StJal, StJalr, StLinkWb, StLui
    } state_t;

    typedef enum logic [2:0] {
        AluAdd  = 3'b000,
        AluSub  = 3'b001,
        AluAnd  = 3'b010,
        AluOr   = 3'b011,
        AluSlt  = 3'b100,
        AluSltu = 3'b101,
        AluXor  = 3'b110
    } aluOp_t;

    typedef enum logic [2:0] {
        ImmI = 3'b000,
        ImmS = 3'b001,
        ImmB = 3'b010,
        ImmJ = 3'b011,
        ImmU = 3'b100
    } immSrc_t;

    typedef enum logic [1:0] {
        SrcAPc    = 2'd0,
        SrcAOldPc = 2'd1,
        SrcARegA  = 2'd2,
        SrcAZero  = 2'd3
    } aluSrcA_t;

    typedef enum logic [1:0] {
        SrcBRegB = 2'd0,
        SrcBImm  = 2'd1,
        SrcBFour = 2'd2,
        SrcBZero = 2'd3
    } aluSrcB_t;

    typedef enum logic [1:0] {
        ResAluOutReg = 2'd0,
        ResMdr       = 2'd1,
        ResAluOut    = 2'd2
    } resultSrc_t;

endpackage

// File: rtl/alu_decoder.sv
// Maps funct3/funct7[5] of R-type and I-ALU instructions onto an ALU operation.
// Shift encodings are not supported and are flagged as illegal.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] Op,
    input  logic [2:0] Funct3,
    input  logic       Funct7b5,
    output logic [2:0] AluOp,
    output logic       Illegal
);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        AluOp   = AluAdd;
        Illegal = 1'b0;
        unique case (Funct3)
            // Inst[30] selects sub only in R-type; in addi it is immediate bit 10.
            3'b000:  AluOp = (Op == OpR && Funct7b5) ? AluSub : AluAdd;
            3'b111:  AluOp = AluAnd;
            3'b110:  AluOp = AluOr;
            3'b100:  AluOp = AluXor;
            3'b010:  AluOp = AluSlt;
            3'b011:  AluOp = AluSltu;
            default: Illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/main_controller.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback.
// Outputs are decoded from the state and the held instruction fields; PcEn in BRANCH also follows Zero.
module main_controller
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] Op,
    input  logic [2:0] Funct3,
    input  logic       Funct7b5,
    input  logic       Zero,
    output logic       PcEn,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IrWrite,
    output logic       RegWrite,
    output logic [1:0] AluSrcA,
    output logic [1:0] AluSrcB,
    output logic [1:0] ResultSrc,
    output logic [2:0] Immsrc,
    output logic [2:0] AluOp,
    output logic       Illegal
);

    state_t     state;
    logic [2:0] decAluOp;
    logic       decIllegal;
    logic       opIllegal;
    logic       decodeIllegal;

    alu_decoder uAluDecoder (
        .Op       (Op),
        .Funct3   (Funct3),
        .Funct7b5 (Funct7b5),
        .AluOp    (decAluOp),
        .Illegal  (decIllegal)
    );

    always_comb begin
        opIllegal     = !(Op inside {OpLoad, OpStore, OpR, OpI, OpBranch, OpJal, OpJalr, OpLui});
        decodeIllegal = opIllegal || ((Op == OpR || Op == OpI) && decIllegal);
    end

    // NOTE: state is sequential, so it is assigned with <= only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= StFetch;
        end else begin
            unique case (state)
                StFetch:  state <= StDecode;
                StDecode: begin
                    if (decodeIllegal) begin
                        state <= StFetch;
                    end else begin
                        unique case (Op)
                            OpLoad, OpStore: state <= StMemAdr;
                            OpR:             state <= StExecR;
                            OpI:             state <= StExecI;
                            OpBranch:        state <= StBranch;
                            OpJal:           state <= StJal;
                            OpJalr:          state <= StJalr;
                            OpLui:           state <= StLui;
                            default:         state <= StFetch;
                        endcase
                    end
                end
                StMemAdr:   state <= (Op == OpStore) ? StMemWrite : StMemRead;
                StMemRead:  state <= StMemWb;
                StExecR,
                StExecI:    state <= StAluWb;
                StJal,
                StJalr:     state <= StLinkWb;
                default:    state <= StFetch;
            endcase
        end
    end

    always_comb begin
        PcEn      = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IrWrite   = 1'b0;
        RegWrite  = 1'b0;
        AluSrcA   = SrcAPc;
        AluSrcB   = SrcBRegB;
        ResultSrc = ResAluOutReg;
        Immsrc    = ImmI;
        AluOp     = AluAdd;
        Illegal   = 1'b0;
        // Reset is synchronous for the state but must silence every enable immediately.
        if (rst) begin
            unique case (state)
                StFetch: begin
                    IrWrite   = 1'b1;
                    AluSrcB   = SrcBFour;
                    ResultSrc = ResAluOut;
                    PcEn      = 1'b1;
                end
                StDecode: begin
                    AluSrcA = SrcAOldPc;
                    AluSrcB = SrcBImm;
                    Immsrc  = (Op == OpJal) ? ImmJ : ImmB;
                    Illegal = decodeIllegal;
                end
                StMemAdr: begin
                    AluSrcA = SrcARegA;
                    AluSrcB = SrcBImm;
                    Immsrc  = (Op == OpStore) ? ImmS : ImmI;
                end
                StMemRead: AdrSrc = 1'b1;
                StMemWb: begin
                    ResultSrc = ResMdr;
                    RegWrite  = 1'b1;
                end
                StMemWrite: begin
                    AdrSrc   = 1'b1;
                    MemWrite = 1'b1;
                end
                StExecR: begin
                    AluSrcA = SrcARegA;
                    AluOp   = decAluOp;
                end
                StExecI: begin
                    AluSrcA = SrcARegA;
                    AluSrcB = SrcBImm;
                    AluOp   = decAluOp;
                end
                StAluWb: RegWrite = 1'b1;
                StBranch: begin
                    AluSrcA = SrcARegA;
                    // blt/bge reuse slt: a nonzero slt result means rs1 < rs2.
                    unique case (Funct3)
                        3'b000: begin AluOp = AluSub; PcEn = Zero;  end
                        3'b001: begin AluOp = AluSub; PcEn = !Zero; end
                        3'b100: begin AluOp = AluSlt; PcEn = !Zero; end
                        3'b101: begin AluOp = AluSlt; PcEn = Zero;  end
                        default: Illegal = 1'b1;
                    endcase
                end
                StJal: PcEn = 1'b1;
                StJalr: begin
                    AluSrcA   = SrcARegA;
                    AluSrcB   = SrcBImm;
                    ResultSrc = ResAluOut;
                    PcEn      = 1'b1;
                end
                StLinkWb: begin
                    AluSrcA   = SrcAOldPc;
                    AluSrcB   = SrcBZero;
                    ResultSrc = ResAluOut;
                    RegWrite  = 1'b1;
                end
                StLui: begin
                    AluSrcA   = SrcAZero;
                    AluSrcB   = SrcBImm;
                    Immsrc    = ImmU;
                    ResultSrc = ResAluOut;
                    RegWrite  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_main_controller.sv
// Scoreboard bench for main_controller: each driven cycle queues the expected control word,
// which is popped and compared at the following falling edge.
module tb_main_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] Op;
    logic [2:0] Funct3;
    logic       Funct7b5;
    logic       Zero;
    logic       PcEn, AdrSrc, MemWrite, IrWrite, RegWrite, Illegal;
    logic [1:0] AluSrcA, AluSrcB, ResultSrc;
    logic [2:0] Immsrc, AluOp;

    typedef struct {
        string       tag;
        logic [17:0] exp;
    } expect_t;

    expect_t sb[$];
    int      vectors = 0;
    int      miscompares = 0;

    main_controller dut (
        .clk       (clk),
        .rst       (rst),
        .Op        (Op),
        .Funct3    (Funct3),
        .Funct7b5  (Funct7b5),
        .Zero      (Zero),
        .PcEn      (PcEn),
        .AdrSrc    (AdrSrc),
        .MemWrite  (MemWrite),
        .IrWrite   (IrWrite),
        .RegWrite  (RegWrite),
        .AluSrcA   (AluSrcA),
        .AluSrcB   (AluSrcB),
        .ResultSrc (ResultSrc),
        .Immsrc    (Immsrc),
        .AluOp     (AluOp),
        .Illegal   (Illegal)
    );

    always #5 clk = ~clk;

    // Control word layout: {PcEn, AdrSrc, MemWrite, IrWrite, RegWrite, A, B, Result, Imm, AluOp, Illegal}
    function automatic logic [17:0] vec(input logic pc, input logic adr, input logic mw,
                                        input logic ir, input logic rw, input logic [1:0] a,
                                        input logic [1:0] b, input logic [1:0] res,
                                        input logic [2:0] imm, input logic [2:0] alu,
                                        input logic ill);
        return {pc, adr, mw, ir, rw, a, b, res, imm, alu, ill};
    endfunction

    task automatic check(input string tag, input logic [17:0] observed, input logic [17:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic step(input string tag, input logic [17:0] exp);
        expect_t e;
        sb.push_back('{tag, exp});
        @(negedge clk);
        e = sb.pop_front();
        check(e.tag, {PcEn, AdrSrc, MemWrite, IrWrite, RegWrite, AluSrcA, AluSrcB, ResultSrc,
                      Immsrc, AluOp, Illegal}, e.exp);
        @(posedge clk);
        #1;
    endtask

    task automatic setInst(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
        Op = op; Funct3 = f3; Funct7b5 = f7; Zero = z;
    endtask

    task automatic fetchDecode(input string tag, input logic [2:0] imm, input logic ill);
        step({tag, ":fetch"},  vec(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd2, 2'd2, 3'd0, 3'd0, 1'b0));
        step({tag, ":decode"}, vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 2'd0, imm, 3'd0, ill));
    endtask

    task automatic runR(input string tag, input logic [2:0] f3, input logic f7, input logic [2:0] alu);
        setInst(7'b0110011, f3, f7, 1'b0);
        fetchDecode(tag, 3'd2, 1'b0);
        step({tag, ":execr"}, vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 2'd0, 3'd0, alu, 1'b0));
        step({tag, ":aluwb"}, vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b0));
    endtask

    task automatic runI(input string tag, input logic [2:0] f3, input logic f7, input logic [2:0] alu);
        setInst(7'b0010011, f3, f7, 1'b0);
        fetchDecode(tag, 3'd2, 1'b0);
        step({tag, ":execi"}, vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 2'd0, 3'd0, alu, 1'b0));
        step({tag, ":aluwb"}, vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b0));
    endtask

    task automatic runBranch(input string tag, input logic [2:0] f3, input logic z,
                             input logic [2:0] alu, input logic taken);
        setInst(7'b1100011, f3, 1'b0, z);
        fetchDecode(tag, 3'd2, 1'b0);
        step({tag, ":branch"}, vec(taken, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 2'd0, 3'd0, alu, 1'b0));
    endtask

    task automatic runIllegal(input string tag, input logic [6:0] op, input logic [2:0] f3);
        setInst(op, f3, 1'b0, 1'b0);
        fetchDecode(tag, 3'd2, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        setInst(7'b0110011, 3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step("reset", 18'd0);
        rst = 1'b1;

        // lw: five cycles
        setInst(7'b0000011, 3'b010, 1'b0, 1'b0);
        fetchDecode("lw", 3'd2, 1'b0);
        step("lw:memadr",  vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 2'd0, 3'd0, 3'd0, 1'b0));
        step("lw:memread", vec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b0));
        step("lw:memwb",   vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd1, 3'd0, 3'd0, 1'b0));

        // sw: four cycles
        setInst(7'b0100011, 3'b010, 1'b0, 1'b0);
        fetchDecode("sw", 3'd2, 1'b0);
        step("sw:memadr",   vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 2'd0, 3'd1, 3'd0, 1'b0));
        step("sw:memwrite", vec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b0));

        runR("add",  3'b000, 1'b0, 3'b000);
        runR("sub",  3'b000, 1'b1, 3'b001);
        runR("and",  3'b111, 1'b0, 3'b010);
        runR("or",   3'b110, 1'b0, 3'b011);
        runR("xor",  3'b100, 1'b0, 3'b110);
        runR("slt",  3'b010, 1'b0, 3'b100);
        runR("sltu", 3'b011, 1'b0, 3'b101);
        runI("addi_f7", 3'b000, 1'b1, 3'b000);
        runI("andi",    3'b111, 1'b0, 3'b010);
        runI("sltiu",   3'b011, 1'b0, 3'b101);

        runBranch("bne_z0", 3'b001, 1'b0, 3'b001, 1'b1);
        runBranch("bge_z0", 3'b101, 1'b0, 3'b100, 1'b0);
        runBranch("beq_z1", 3'b000, 1'b1, 3'b001, 1'b1);
        runBranch("beq_z0", 3'b000, 1'b0, 3'b001, 1'b0);
        runBranch("blt_z0", 3'b100, 1'b0, 3'b100, 1'b1);

        // jal
        setInst(7'b1101111, 3'b000, 1'b0, 1'b0);
        fetchDecode("jal", 3'd3, 1'b0);
        step("jal:jal",    vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b0));
        step("jal:linkwb", vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd3, 2'd2, 3'd0, 3'd0, 1'b0));

        // jalr
        setInst(7'b1100111, 3'b000, 1'b0, 1'b0);
        fetchDecode("jalr", 3'd2, 1'b0);
        step("jalr:jalr",   vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 2'd2, 3'd0, 3'd0, 1'b0));
        step("jalr:linkwb", vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd3, 2'd2, 3'd0, 3'd0, 1'b0));

        // lui
        setInst(7'b0110111, 3'b000, 1'b0, 1'b0);
        fetchDecode("lui", 3'd2, 1'b0);
        step("lui:lui", vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 2'd1, 2'd2, 3'd4, 3'd0, 1'b0));

        runIllegal("op7f", 7'b1111111, 3'b000);
        runIllegal("slli", 7'b0010011, 3'b001);
        runIllegal("srl",  7'b0110011, 3'b101);

        // Reset during lw, before the write-back cycle
        setInst(7'b0000011, 3'b010, 1'b0, 1'b0);
        fetchDecode("lwrst", 3'd2, 1'b0);
        step("lwrst:memadr", vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 2'd0, 3'd0, 3'd0, 1'b0));
        rst = 1'b0;
        step("lwrst:held0", 18'd0);
        step("lwrst:held1", 18'd0);
        rst = 1'b1;

        runR("after_rst", 3'b000, 1'b0, 3'b000);
        step("final:fetch", vec(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd2, 2'd2, 3'd0, 3'd0, 1'b0));

        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard: observed %0d leftover entries expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
